// File: rtl/product_rx.sv
// Serial receiver for signed product frames: start, DATA_BITS data bits LSB first, stop.
// Define PRODUCT_RX_PARITY_EN to add an even-parity bit between the data bits and the stop bit.
module product_rx #(
    parameter int DATA_BITS = 8
) (
    input  logic                        CLK,
    input  logic                        rst,
    input  logic                        rx,
    output logic signed [DATA_BITS-1:0] out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        frame_err,
    output logic                        parity_err,
    output logic                        overrun,
    output logic [7:0]                  err_count,
    output logic [2:0]                  state_dbg
);
    // Handshake: a beat transfers on a rising CLK edge where out_valid and out_ready are both 1;
    // out_data holds steady while out_valid=1 and out_ready=0.

    localparam int CNT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DATA   = 3'd1,
        PARITY = 3'd2,
        STOP   = 3'd3,
        RESYNC = 3'd4
    } state_t;

    state_t               state;
    logic [CNT_W-1:0]     bit_cnt;
    logic [DATA_BITS-1:0] shift;

    logic at_stop;
    logic par_bad;
    logic frame_good;
    logic fe_n;
    logic pe_n;
    logic ov_n;
    logic any_err;

`ifdef PRODUCT_RX_PARITY_EN
    logic parity_bit;
    assign par_bad = parity_bit != (^shift);
`else
    assign par_bad    = 1'b0;
    assign parity_err = 1'b0;
`endif

    // Every frame outcome is decided on the edge that samples the stop bit.
    always_comb begin
        at_stop    = (state == STOP);
        frame_good = at_stop && rx && !par_bad;
        fe_n       = at_stop && !rx;
        pe_n       = at_stop && par_bad;
        ov_n       = frame_good && out_valid && !out_ready;
        any_err    = fe_n || pe_n || ov_n;
    end

    assign state_dbg = state;

    always_ff @(posedge CLK) begin
        if (rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shift     <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            err_count <= 8'd0;
`ifdef PRODUCT_RX_PARITY_EN
            parity_err <= 1'b0;
            parity_bit <= 1'b0;
`endif
        end else begin
            frame_err <= fe_n;
            overrun   <= ov_n;
`ifdef PRODUCT_RX_PARITY_EN
            parity_err <= pe_n;
`endif
            if (any_err && err_count != 8'hFF) begin
                err_count <= err_count + 8'd1;
            end

            // A completing frame may replace a beat being consumed in the same cycle.
            if (frame_good && (!out_valid || out_ready)) begin
                out_data  <= shift;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (!rx) begin
                        state   <= DATA;
                        bit_cnt <= '0;
                    end
                end
                DATA: begin
                    shift[bit_cnt] <= rx;
                    bit_cnt        <= bit_cnt + CNT_W'(1);
                    if (bit_cnt == LAST_BIT) begin
`ifdef PRODUCT_RX_PARITY_EN
                        state <= PARITY;
`else
                        state <= STOP;
`endif
                    end
                end
                PARITY: begin
`ifdef PRODUCT_RX_PARITY_EN
                    parity_bit <= rx;
`endif
                    state <= STOP;
                end
                STOP: begin
                    state <= rx ? IDLE : RESYNC;
                end
                RESYNC: begin
                    if (rx) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/product_rx.md
PRODUCT_RX -- requirements
Module: product_rx

Interface
REQ-001 The block SHALL take the parameter DATA_BITS, default 8: the number of payload bits per frame.
REQ-002 The port CLK SHALL be an input, 1 bit wide: the single global clock; all state updates on its rising edge.
REQ-003 The port rst SHALL be an input, 1 bit wide: reset, synchronous and active-high.
REQ-004 The port rx SHALL be an input, 1 bit wide: the serial line carrying product frames, one bit per CLK cycle; idles high.
REQ-005 The port out_data SHALL be an output, DATA_BITS wide, signed: the last accepted product.
REQ-006 The port out_valid SHALL be an output, 1 bit wide: out_data holds an unconsumed product.
REQ-007 The port out_ready SHALL be an input, 1 bit wide: the consumer accepts out_data this cycle.
REQ-008 The port frame_err SHALL be an output, 1 bit wide: 1-cycle pulse, a stop bit was sampled low.
REQ-009 The port parity_err SHALL be an output, 1 bit wide: 1-cycle pulse, a parity mismatch was detected.
REQ-010 The port overrun SHALL be an output, 1 bit wide: 1-cycle pulse, a good frame was dropped because the holding register was full.
REQ-011 The port err_count SHALL be an output, 8 bits wide: a saturating count of frame_err, parity_err and overrun events.

Function
REQ-012 Frame format SHALL be: start (0), DATA_BITS data bits LSB first, optional parity (REQ-026), stop (1). No oversampling: rx is sampled once per CLK edge.
REQ-013 States SHALL be IDLE, DATA, PARITY, STOP and RESYNC.
REQ-014 IDLE SHALL move to DATA when rx=0 is sampled, clearing bit_cnt to 0; otherwise it stays in IDLE.
REQ-015 DATA SHALL write rx into shift[bit_cnt] and increment bit_cnt; after bit DATA_BITS-1 it moves to PARITY when enabled, else to STOP.
REQ-016 STOP with rx=1 SHALL mark the frame good and return to IDLE, so back-to-back frames with no idle gap are accepted.
REQ-017 STOP with rx=0 SHALL pulse frame_err, discard the frame and move to RESYNC; RESYNC stays until rx=1 is sampled, then moves to IDLE.
REQ-018 Latency: for a start bit sampled at edge k, out_valid and out_data SHALL be visible after edge k+DATA_BITS+1 (k+DATA_BITS+2 with parity).
REQ-019 On a good frame with out_valid=0, or with out_valid=1 and out_ready=1 in the same cycle, shift SHALL load into out_data and out_valid SHALL be 1 on the next cycle.
REQ-020 On a good frame with out_valid=1 and out_ready=0, the frame SHALL be dropped, out_data SHALL be unchanged and overrun SHALL pulse.
REQ-021 out_valid=1 with out_ready=1 and no good frame completing SHALL clear out_valid on the next edge.
REQ-022 out_data SHALL be stable while out_valid=1 and out_ready=0.
REQ-023 err_count SHALL add 1 per cycle in which any error pulse is asserted (at most 1 per cycle) and SHALL saturate at 255.

Reset
REQ-024 rst=1 at a CLK edge SHALL force state IDLE, bit_cnt=0, shift=0, out_data=0, out_valid=0, frame_err=0, parity_err=0, overrun=0 and err_count=0.
REQ-025 rst asserted mid-frame SHALL discard the partial frame; the first frame accepted after release SHALL begin with a start bit sampled after rst deasserts.

Configuration
REQ-026 With PRODUCT_RX_PARITY_EN defined, one even-parity bit SHALL follow the data bits: PARITY samples rx, a mismatch pulses parity_err at the STOP-state edge, and the frame is discarded even when the stop bit is good.
REQ-027 Without PRODUCT_RX_PARITY_EN, the PARITY state SHALL be unreachable, parity_err SHALL be tied 0, and the frame SHALL be 10 bits at DATA_BITS=8.

Verification
REQ-028 The bench SHALL drive rx = 0,0,1,0,1,1,1,1,1,1 (product -6, 0xFA) with out_ready=1 and require out_data=0xFA and out_valid high one cycle after the stop bit.
REQ-029 The bench SHALL send frames 0xFA and 0x09 back to back with no gap, out_ready=1, and require two valid beats carrying 0xFA then 0x09.
REQ-030 The bench SHALL hold out_ready=0, send 0x12 then 0x34, and require out_data=0x12, overrun pulsed once and err_count=1.
REQ-031 The bench SHALL send a frame with a low stop bit followed by rx held 0 for 5 cycles, then high, then 0x05, and require frame_err once, no valid for the bad frame and out_data=0x05.
REQ-032 The bench SHALL assert rst at data bit 4 of a frame, then send 0x7F, and require all outputs 0 during reset and out_data=0x7F afterwards.
REQ-033 With PRODUCT_RX_PARITY_EN defined, the bench SHALL send 0x03 with parity bit 1 and require parity_err to pulse, out_valid to stay 0 and err_count=1.
